// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt front end: synchronizes and edge-detects external requests into sticky
// pending bits, picks the lowest eligible index, and handshakes with the control FSM.
module otter_intr_ctrl #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] INTR_IN,
  input  logic [NUM_SRC-1:0] EN_MASK,
  input  logic               MIE,
  input  logic               INT_TAKEN,
  input  logic               MRET_EXEC,
  output logic               INT_REQ,
  output logic [IDW-1:0]     INT_ID,
  output logic [NUM_SRC-1:0] PENDING,
  output logic               IN_SERVICE
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [IDW-1:0]     sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= INTR_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign elig = pend_q & EN_MASK;

  // Descending scan so the lowest set index is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) sel = IDW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      StIdle: begin
        if (MIE && (|elig)) begin
          id_d    = sel;
          state_d = StReq;
        end
      end
      StReq: begin
        if (INT_TAKEN) begin
          clr     = NUM_SRC'(1) << id_q;
          state_d = StService;
        end else if (!MIE || !elig[id_q]) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (MRET_EXEC) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A fresh rise on the source being taken keeps it pending.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      id_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
    end
  end

  assign INT_REQ    = (state_q == StReq);
  assign IN_SERVICE = (state_q == StService);
  assign INT_ID     = id_q;
  assign PENDING    = pend_q;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Randomized bench for otter_intr_ctrl: a behavioural model predicts the outputs after every
// edge into a scoreboard; a monitor on the falling edge pops and compares.
module tb_otter_intr_ctrl;

  localparam int N   = 4;
  localparam int S   = 2;
  localparam int IDW = 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   INTR_IN;
  logic [N-1:0]   EN_MASK;
  logic           MIE;
  logic           INT_TAKEN;
  logic           MRET_EXEC;
  logic           INT_REQ;
  logic [IDW-1:0] INT_ID;
  logic [N-1:0]   PENDING;
  logic           IN_SERVICE;

  otter_intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .INTR_IN    (INTR_IN),
    .EN_MASK    (EN_MASK),
    .MIE        (MIE),
    .INT_TAKEN  (INT_TAKEN),
    .MRET_EXEC  (MRET_EXEC),
    .INT_REQ    (INT_REQ),
    .INT_ID     (INT_ID),
    .PENDING    (PENDING),
    .IN_SERVICE (IN_SERVICE)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt++;

  typedef struct {
    int           tgt;
    logic         req;
    logic [IDW-1:0] id;
    logic [N-1:0] pend;
    logic         svc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Model state: pending set, handshake phase (0 idle, 1 requesting, 2 in service), chosen id.
  logic [N-1:0] m_pend;
  int           m_mode;
  int           m_id;
  logic [N-1:0] raw_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt,
               $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_mode = 0;
    m_id   = 0;
    raw_q.delete();
    for (int i = 0; i < S + 1; i++) raw_q.push_back('0);
  endtask

  // Predict the state after the coming edge from the inputs now being applied.
  task automatic model_edge();
    logic [N-1:0] rise, elig, clr;
    exp_t e;
    raw_q.push_back(INTR_IN);
    if (raw_q.size() > S + 2) void'(raw_q.pop_front());
    // A raw rise is seen as pending SYNC_STAGES edges after it was sampled.
    rise = raw_q[1] & ~raw_q[0];
    elig = m_pend & EN_MASK;
    clr  = '0;
    case (m_mode)
      0: if (MIE && elig != 0) begin m_id = lowest(elig); m_mode = 1; end
      1: begin
        if (INT_TAKEN) begin clr[m_id] = 1'b1; m_mode = 2; end
        else if (!MIE || !elig[m_id]) m_mode = 0;
      end
      default: if (MRET_EXEC) m_mode = 0;
    endcase
    m_pend = (m_pend & ~clr) | rise;
    e.tgt  = edge_cnt + 1;
    e.req  = (m_mode == 1);
    e.id   = IDW'(m_id);
    e.pend = m_pend;
    e.svc  = (m_mode == 2);
    sb.push_back(e);
  endtask

  // Reset asserted between edges; outputs must clear with no clock.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("rst_int_req", 32'(INT_REQ), 32'd0);
    check("rst_int_id", 32'(INT_ID), 32'd0);
    check("rst_pending", 32'(PENDING), 32'd0);
    check("rst_in_service", 32'(IN_SERVICE), 32'd0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0] v;
    v = INTR_IN;
    for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) v[i] = ~v[i];
    INTR_IN = v;
    v = EN_MASK;
    for (int i = 0; i < N; i++) if ($urandom_range(31) == 0) v[i] = ~v[i];
    EN_MASK = v;
    if ($urandom_range(11) == 0) MIE = ~MIE;
    INT_TAKEN = (m_mode == 1) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
    MRET_EXEC = (m_mode == 2) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
    model_edge();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].tgt <= edge_cnt) begin
        e = sb.pop_front();
        if (e.tgt < edge_cnt) begin
          check("stale_expectation", 32'(edge_cnt), 32'(e.tgt));
        end else begin
          check("int_req", 32'(INT_REQ), 32'(e.req));
          check("int_id", 32'(INT_ID), 32'(e.id));
          check("pending", 32'(PENDING), 32'(e.pend));
          check("in_service", 32'(IN_SERVICE), 32'(e.svc));
        end
      end
    end
  end

  initial begin : driver
    int next_rst;
    INTR_IN   = '0;
    EN_MASK   = '1;
    MIE       = 1'b1;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    model_reset();
    do_reset();
    next_rst = 700;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc >= next_rst && (m_mode == 2 || cyc >= next_rst + 200)) begin
        do_reset();
        next_rst += 700;
      end
      step();
      @(posedge CLK);
      #2;
    end
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
- Interrupt front end for the OTTER MCU, directly upstream of the CSR block and the control-unit FSM.
- Synchronizes NUM_SRC asynchronous external request lines and edge-detects them into sticky pending bits.
- Arbitrates by fixed priority, gates with MIE from the CSR, and runs a request/taken/return handshake with the control FSM.
- The control FSM's INT_TAKEN and MRET_EXEC pulses are the same signals that drive the CSR.

Parameters:
- NUM_SRC, 4: number of interrupt sources; legal range 1..16.
- SYNC_STAGES, 2: synchronizer flops per source; legal range 2..3.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- INTR_IN  in  NUM_SRC  raw asynchronous request lines, active-high level.
- EN_MASK  in  NUM_SRC  per-source enable; 1 = eligible for arbitration.
- MIE  in  1  global interrupt enable, from CSR MSTATUS[3].
- INT_TAKEN  in  1  one-cycle pulse from the control FSM when the trap is entered.
- MRET_EXEC  in  1  one-cycle pulse from the control FSM when mret executes.
- INT_REQ  out  1  registered request to the control FSM.
- INT_ID  out  IDW  selected or in-service source index; IDW = max(1, clog2(NUM_SRC)).
- PENDING  out  NUM_SRC  sticky pending bits, status only.
- IN_SERVICE  out  1  high while a taken interrupt awaits mret.

Behaviour:
- Reset (async, immediate on RST=1): all sync flops, edge-history flops and PENDING = 0; state = IDLE; INT_REQ = 0; INT_ID = 0; IN_SERVICE = 0. Reset mid-service aborts it and discards all pending events.
- Synchronizer: each source passes through a SYNC_STAGES flop chain. A history flop holds the previous synced value.
  - rise[i] = synced[i] & ~hist[i].
  - rise[i] sets PENDING[i] on the next edge.
  - Latency: INTR_IN high before edge k → PENDING[i] = 1 after edge k+SYNC_STAGES.
  - A level held high produces exactly one event; it must drop and rise again to re-pend.
  - Pulses shorter than one CLK period may be lost; this is not required behaviour.
- Eligible vector: elig = PENDING & EN_MASK. Priority is fixed: the lowest index wins.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - INT_REQ = 0.
  - If MIE=1 and elig != 0: latch INT_ID = lowest set index of elig and go to REQ on the same edge.
  - INT_TAKEN and MRET_EXEC are ignored.
- REQ:
  - INT_REQ = 1; INT_ID is held stable. A higher-priority arrival does not re-select.
  - If INT_TAKEN=1: clear PENDING[INT_ID], go to SERVICE.
  - Else if MIE=0 or elig[INT_ID]=0: withdraw and return to IDLE. PENDING is untouched.
  - INT_TAKEN has priority over withdrawal in the same cycle.
- SERVICE:
  - INT_REQ = 0; IN_SERVICE = 1; INT_ID is held.
  - On MRET_EXEC: go to IDLE. Re-arbitration starts in the following cycle, so a back-to-back pending source raises INT_REQ 2 edges after MRET_EXEC.
  - INT_TAKEN is ignored.
  - No nesting: new pending events accumulate but do not request.
- Simultaneous set and clear on the same bit (a new rise on the source being taken): set wins, so PENDING stays 1.
- Pending bits of non-selected sources are never cleared by a handshake.
- EN_MASK = 0 on a source does not clear its PENDING bit; the event is serviced once the source is re-enabled.
- INT_REQ is registered (a state decode of a flop) and must not depend combinationally on any input.

Test Plan:
- Reset, then a single pulse: RST=1 for 2 cycles; MIE=1, EN_MASK=4'hF; INTR_IN[2] rises before edge 0 → PENDING=4'b0100 after edge 2; INT_REQ=1, INT_ID=2 after edge 3; INT_TAKEN pulse → PENDING=0, IN_SERVICE=1; MRET_EXEC → IDLE, INT_REQ stays 0.
- Priority and hold: sources 3 and 1 rise together → INT_ID=1; source 0 rises while in REQ → INT_ID stays 1. After taken and mret, INT_REQ returns with INT_ID=0, then later with INT_ID=3.
- Gating and withdrawal: PENDING[0]=1 with MIE=0 → INT_REQ stays 0 indefinitely. MIE=1 → request raised. MIE=0 in REQ with no INT_TAKEN → back to IDLE, INT_REQ=0, PENDING[0] still 1. MIE=1 again → re-request with INT_ID=0.
- Level and mask: INTR_IN[1] held high for 20 cycles → exactly one taken event. EN_MASK[1]=0 while pending → no request. Unmask → request with INT_ID=1.
- Set/clear collision: INTR_IN[2] toggles so its rise lands in the INT_TAKEN cycle for ID 2 → PENDING[2]=1 afterwards; a second request for ID 2 follows mret.
- Async reset mid-service: assert RST between clock edges while in SERVICE with PENDING=4'b1010 → outputs go to zero immediately, without a clock; after release, no request until new edges arrive.
